gray_track_rx: RTL and testbench

Receiving end of the Gray-code path: accepts a stream of W-bit Gray-coded samples from the existing binary-to-Gray encoder's output, decodes each sample back to binary, and classifies each step against the previous sample as hold, up, down or illegal. A signed position counter and a saturating error counter are maintained. Sits downstream of the encoder/counter link, ahead of any consumer that needs binary position, with valid/ready flow control on both sides.

---
 rtl/gray_track_rx_pkg.sv | 16 +
 rtl/gray_track_rx_gray2bin.sv | 13 +
 rtl/gray_track_rx.sv | 139 +++++++++++++
 tb/tb_gray_track_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_track_rx_pkg.sv
// Shared encodings for the Gray-code receive path: step classes and tracker states.
package gray_track_rx_pkg;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_ERR  = 2'b11
    } dir_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

endpackage

// File: rtl/gray_track_rx_gray2bin.sv
// Purely combinational Gray-to-binary decode; each binary bit is the XOR of all Gray bits at or above it.
module gray_track_rx_gray2bin #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/gray_track_rx.sv
// Gray-code sample tracker: decodes each accepted sample, classifies the step against the
// previous one, and keeps a wrapping position counter plus a saturating illegal-step counter.
module gray_track_rx
    import gray_track_rx_pkg::*;
#(
    parameter int unsigned W     = 3,
    parameter int unsigned POS_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_gray_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_bin_o,
    output logic [1:0]       out_dir_o,
    output logic [POS_W-1:0] pos_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             err_pulse_o
);

    // state    | meaning
    // ST_INIT  | no reference sample; next accepted sample is HOLD and becomes reference
    // ST_TRACK | prev_q holds the reference; steps are classified against it

    state_e           state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_bin_q, out_bin_d;
    dir_e             out_dir_q, out_dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_pulse_q, err_pulse_d;

    logic             accept;
    logic [W-1:0]     bin;
    logic [W-1:0]     delta;
    dir_e             dir;

    gray_track_rx_gray2bin #(.W(W)) u_gray2bin (
        .gray_i (in_gray_i),
        .bin_o  (bin)
    );

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign delta      = bin - prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = ST_INIT;
        end
        if (accept) begin
            state_d = ST_TRACK;
        end
    end

    // A clr in the same cycle as an accept forces the sample to be treated as the new reference.
    always_comb begin
        dir = DIR_HOLD;
        if (!clr_i && state_q == ST_TRACK) begin
            if (delta == '0) begin
                dir = DIR_HOLD;
            end else if (delta == W'(1)) begin
                dir = DIR_UP;
            end else if (delta == '1) begin
                dir = DIR_DOWN;
            end else begin
                dir = DIR_ERR;
            end
        end

        prev_d      = prev_q;
        out_bin_d   = out_bin_q;
        out_dir_d   = out_dir_q;
        pos_d       = clr_i ? '0 : pos_q;
        err_d       = clr_i ? '0 : err_q;
        err_pulse_d = 1'b0;
        out_valid_d = out_valid_q && !out_ready_i;

        if (accept) begin
            prev_d      = bin;
            out_bin_d   = bin;
            out_dir_d   = dir;
            out_valid_d = 1'b1;
            case (dir)
                DIR_UP:   pos_d = pos_q + POS_W'(1);
                DIR_DOWN: pos_d = pos_q - POS_W'(1);
                DIR_ERR: begin
                    err_pulse_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_dir_q   <= DIR_HOLD;
            pos_q       <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_dir_q   <= out_dir_d;
            pos_q       <= pos_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_bin_o   = out_bin_q;
    assign out_dir_o   = out_dir_q;
    assign pos_o       = pos_q;
    assign err_cnt_o   = err_q;
    assign err_pulse_o = err_pulse_q;

endmodule

// File: tb/tb_gray_track_rx.sv
// Directed bench for gray_track_rx: default instance plus a 2-bit error counter instance.
module tb_gray_track_rx;

    logic clk;
    logic rst_n;

    logic        clr_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_pulse_a;
    logic [2:0]  in_gray_a, out_bin_a;
    logic [1:0]  out_dir_a;
    logic [15:0] pos_a;
    logic [7:0]  err_cnt_a;

    logic        clr_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_pulse_b;
    logic [2:0]  in_gray_b, out_bin_b;
    logic [1:0]  out_dir_b;
    logic [15:0] pos_b;
    logic [1:0]  err_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DOWN = 2'b10, ERR = 2'b11;

    gray_track_rx #(.W(3), .POS_W(16), .ERR_W(8)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr_a),
        .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_gray_i(in_gray_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
        .out_bin_o(out_bin_a), .out_dir_o(out_dir_a), .pos_o(pos_a),
        .err_cnt_o(err_cnt_a), .err_pulse_o(err_pulse_a)
    );

    gray_track_rx #(.W(3), .POS_W(16), .ERR_W(2)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr_b),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_gray_i(in_gray_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .out_bin_o(out_bin_b), .out_dir_o(out_dir_b), .pos_o(pos_b),
        .err_cnt_o(err_cnt_b), .err_pulse_o(err_pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_a(input logic v, input logic [2:0] g, input logic c);
        in_valid_a = v;
        in_gray_a  = g;
        clr_a      = c;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        clr_a      = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid_a, out_bin_a, out_dir_a, pos_a, err_cnt_a, err_pulse_a, in_ready_a}
            !== {1'b0, 3'd0, HOLD, 16'd0, 8'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_a: valid=%b bin=%0d dir=%b pos=%h err=%0d pulse=%b rdy=%b (want 0 0 00 0000 0 0 1)",
                     out_valid_a, out_bin_a, out_dir_a, pos_a, err_cnt_a, err_pulse_a, in_ready_a);
        end
        n_cmp++;
        if ({out_valid_b, err_cnt_b, pos_b, in_ready_b} !== {1'b0, 2'd0, 16'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_b: valid=%b err=%0d pos=%h rdy=%b (want 0 0 0000 1)",
                     out_valid_b, err_cnt_b, pos_b, in_ready_b);
        end
    endtask

    task automatic test_count_up;
        logic [2:0] gseq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        logic [2:0] bseq [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        out_ready_a = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_a(1'b1, gseq[i], 1'b0);
            n_cmp++;
            if ({out_valid_a, out_bin_a, out_dir_a, pos_a} !== {1'b1, bseq[i], (i == 0) ? HOLD : UP, 16'(i)}) begin
                n_bad++;
                $display("FAIL up_step%0d: valid=%b bin=%0d dir=%b pos=%0d (want 1 %0d %b %0d)",
                         i, out_valid_a, out_bin_a, out_dir_a, pos_a, bseq[i], (i == 0) ? HOLD : UP, i);
            end
        end
        n_cmp++;
        if (err_cnt_a !== 8'd0) begin
            n_bad++;
            $display("FAIL up_errcnt: got %0d want 0", err_cnt_a);
        end
    endtask

    task automatic test_count_down;
        logic [2:0] gseq [3] = '{3'b100, 3'b101, 3'b111};
        logic [2:0] bseq [3] = '{3'd7, 3'd6, 3'd5};
        logic [15:0] pseq [3] = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
        drive_a(1'b1, 3'b000, 1'b1);
        n_cmp++;
        if ({out_bin_a, out_dir_a, pos_a} !== {3'd0, HOLD, 16'd0}) begin
            n_bad++;
            $display("FAIL down_ref: bin=%0d dir=%b pos=%h (want 0 00 0000)", out_bin_a, out_dir_a, pos_a);
        end
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, gseq[i], 1'b0);
            n_cmp++;
            if ({out_bin_a, out_dir_a, pos_a} !== {bseq[i], DOWN, pseq[i]}) begin
                n_bad++;
                $display("FAIL down_step%0d: bin=%0d dir=%b pos=%h (want %0d 10 %h)",
                         i, out_bin_a, out_dir_a, pos_a, bseq[i], pseq[i]);
            end
        end
    endtask

    task automatic test_illegal_jump;
        drive_a(1'b1, 3'b000, 1'b1);
        drive_a(1'b1, 3'b110, 1'b0);
        n_cmp++;
        if ({out_bin_a, out_dir_a, pos_a, err_cnt_a, err_pulse_a} !== {3'd4, ERR, 16'd0, 8'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL err_jump: bin=%0d dir=%b pos=%h err=%0d pulse=%b (want 4 11 0000 1 1)",
                     out_bin_a, out_dir_a, pos_a, err_cnt_a, err_pulse_a);
        end
        drive_a(1'b1, 3'b111, 1'b0);
        n_cmp++;
        if ({out_bin_a, out_dir_a, pos_a, err_cnt_a, err_pulse_a} !== {3'd5, UP, 16'd1, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL err_resync: bin=%0d dir=%b pos=%h err=%0d pulse=%b (want 5 01 0001 1 0)",
                     out_bin_a, out_dir_a, pos_a, err_cnt_a, err_pulse_a);
        end
        drive_a(1'b0, 3'b111, 1'b0);
        n_cmp++;
        if (out_valid_a !== 1'b0) begin
            n_bad++;
            $display("FAIL err_drain: out_valid=%b want 0", out_valid_a);
        end
    endtask

    task automatic test_backpressure;
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_gray_a   = 3'b101;
        #1;
        n_cmp++;
        if (in_ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready_empty: in_ready=%b want 1", in_ready_a);
        end
        @(posedge clk);
        #1;
        in_gray_a = 3'b100;
        n_cmp++;
        if ({out_valid_a, out_bin_a, out_dir_a, pos_a} !== {1'b1, 3'd6, UP, 16'd2}) begin
            n_bad++;
            $display("FAIL bp_load: valid=%b bin=%0d dir=%b pos=%0d (want 1 6 01 2)",
                     out_valid_a, out_bin_a, out_dir_a, pos_a);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({in_ready_a, out_valid_a, out_bin_a, out_dir_a, pos_a} !== {1'b0, 1'b1, 3'd6, UP, 16'd2}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: rdy=%b valid=%b bin=%0d dir=%b pos=%0d (want 0 1 6 01 2)",
                         i, in_ready_a, out_valid_a, out_bin_a, out_dir_a, pos_a);
            end
        end
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid_a, out_bin_a, out_dir_a, pos_a} !== {1'b1, 3'd7, UP, 16'd3}) begin
            n_bad++;
            $display("FAIL bp_release: valid=%b bin=%0d dir=%b pos=%0d (want 1 7 01 3)",
                     out_valid_a, out_bin_a, out_dir_a, pos_a);
        end
        drive_a(1'b1, 3'b000, 1'b0);
        n_cmp++;
        if ({out_bin_a, out_dir_a, pos_a} !== {3'd0, UP, 16'd4}) begin
            n_bad++;
            $display("FAIL bp_resume: bin=%0d dir=%b pos=%0d (want 0 01 4)", out_bin_a, out_dir_a, pos_a);
        end
    endtask

    task automatic test_err_saturate;
        logic [2:0] gseq [5] = '{3'b110, 3'b000, 3'b110, 3'b000, 3'b110};
        logic [1:0] eseq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        in_gray_b   = 3'b000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_gray_b = gseq[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_dir_b, err_cnt_b, err_pulse_b} !== {ERR, eseq[i], 1'b1}) begin
                n_bad++;
                $display("FAIL sat_step%0d: dir=%b err=%0d pulse=%b (want 11 %0d 1)",
                         i, out_dir_b, err_cnt_b, err_pulse_b, eseq[i]);
            end
        end
        in_valid_b = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({err_cnt_b, err_pulse_b} !== {2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL sat_idle: err=%0d pulse=%b (want 3 0)", err_cnt_b, err_pulse_b);
        end
    endtask

    task automatic test_clear_and_reset;
        drive_a(1'b1, 3'b001, 1'b0);
        n_cmp++;
        if ({out_dir_a, pos_a, err_cnt_a} !== {UP, 16'd5, 8'd1}) begin
            n_bad++;
            $display("FAIL clr_setup: dir=%b pos=%0d err=%0d (want 01 5 1)", out_dir_a, pos_a, err_cnt_a);
        end
        drive_a(1'b1, 3'b011, 1'b1);
        n_cmp++;
        if ({out_bin_a, out_dir_a, pos_a, err_cnt_a} !== {3'd2, HOLD, 16'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL clr_accept: bin=%0d dir=%b pos=%0d err=%0d (want 2 00 0 0)",
                     out_bin_a, out_dir_a, pos_a, err_cnt_a);
        end
        drive_a(1'b1, 3'b010, 1'b0);
        n_cmp++;
        if ({out_bin_a, out_dir_a, pos_a} !== {3'd3, UP, 16'd1}) begin
            n_bad++;
            $display("FAIL clr_next: bin=%0d dir=%b pos=%0d (want 3 01 1)", out_bin_a, out_dir_a, pos_a);
        end
        out_ready_a = 1'b0;
        drive_a(1'b1, 3'b110, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid_a, pos_a, in_ready_a} !== {1'b0, 16'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_reset: valid=%b pos=%0d rdy=%b (want 0 0 1)", out_valid_a, pos_a, in_ready_a);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr_a = 1'b0; in_valid_a = 1'b0; in_gray_a = '0; out_ready_a = 1'b1;
        clr_b = 1'b0; in_valid_b = 1'b0; in_gray_b = '0; out_ready_b = 1'b1;
        test_reset();
        test_count_up();
        test_count_down();
        test_illegal_jump();
        test_backpressure();
        test_err_saturate();
        test_clear_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
